// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC owner turning jump decisions into PC loads, IF/ID squashes and fetch holds.
// Optional PC_SEQ_PERF_CNT_EN adds saturating redirect_cnt/hold_cnt counters.
module pc_sequencer #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      jump_op,
  input  logic [PC_W-1:0] branch_target,
  input  logic [PC_W-1:0] reg_target,
  input  logic [PC_W-1:0] jump_target,
  input  logic            reg_ready,
  input  logic            stall,
  input  logic            imem_ready,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic            if_id_write,
  output logic            if_id_flush,
  output logic            redirect
`ifdef PC_SEQ_PERF_CNT_EN
 ,output logic [31:0]     redirect_cnt,
  output logic [31:0]     hold_cnt
`endif
);
  typedef enum logic [1:0] {RUN, PEND, SQUASH} state_t;
  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pend_q, pend_d, target;
  logic            hold_req, redir_req;
  assign hold_req  = stall | (jump_op == 2'b10 & !reg_ready);
  assign redir_req = (jump_op != 2'b00) & !hold_req;
  assign target    = (jump_op == 2'b01 ? branch_target :
                      jump_op == 2'b10 ? reg_target : jump_target) & ~PC_W'(3);
  assign pc        = pc_q;
  assign pc_plus4  = pc_q + PC_W'(4);
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    redirect    = 1'b0;
    case (state_q)
      RUN: begin
        if (hold_req) begin
          state_d = RUN;
        end else if (redir_req) begin
          if_id_flush = 1'b1;
          redirect    = imem_ready;
          pc_d        = imem_ready ? target : pc_q;
          pend_d      = imem_ready ? pend_q : target;
          state_d     = imem_ready ? SQUASH : PEND;
        end else begin
          if_id_write = imem_ready;
          pc_d        = imem_ready ? pc_plus4 : pc_q;
        end
      end
      PEND: begin
        if_id_flush = 1'b1;
        redirect    = imem_ready;
        pc_d        = imem_ready ? pend_q : pc_q;
        state_d     = imem_ready ? SQUASH : PEND;
      end
      SQUASH: begin
        if_id_write = imem_ready;
        pc_d        = imem_ready ? pc_plus4 : pc_q;
        state_d     = RUN;
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      if_id_write = 1'b0;
      if_id_flush = 1'b0;
      redirect    = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end
`ifdef PC_SEQ_PERF_CNT_EN
  logic [31:0] redirect_cnt_q, hold_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
  assign hold_cnt     = hold_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt_q <= '0;
      hold_cnt_q     <= '0;
    end else begin
      if (redirect && redirect_cnt_q != '1) redirect_cnt_q <= redirect_cnt_q + 32'd1;
      if (state_q == RUN && hold_req && hold_cnt_q != '1) hold_cnt_q <= hold_cnt_q + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of reset, sequential fetch, redirects, holds and PEND behaviour.
module tb_pc_sequencer;
  localparam logic [31:0] RPC = 32'h0040_0000;
  logic        clk = 1'b0;
  logic        rst, reg_ready, stall, imem_ready;
  logic [1:0]  jump_op;
  logic [31:0] branch_target, reg_target, jump_target, pc, pc_plus4;
  logic        if_id_write, if_id_flush, redirect;
  int          total = 0, bad = 0;
`ifdef PC_SEQ_PERF_CNT_EN
  logic [31:0] redirect_cnt, hold_cnt;
`endif
  pc_sequencer #(.PC_W(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .jump_op(jump_op), .branch_target(branch_target),
    .reg_target(reg_target), .jump_target(jump_target), .reg_ready(reg_ready),
    .stall(stall), .imem_ready(imem_ready), .pc(pc), .pc_plus4(pc_plus4),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .redirect(redirect)
`ifdef PC_SEQ_PERF_CNT_EN
   ,.redirect_cnt(redirect_cnt), .hold_cnt(hold_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; jump_op = 2'b00; branch_target = '0; reg_target = '0; jump_target = '0;
    reg_ready = 1'b1; stall = 1'b0; imem_ready = 1'b1;
    tick; tick;
    chk("rst_pc", pc, RPC);
    chk("rst_write", if_id_write, 0);
    chk("rst_flush", if_id_flush, 0);
    chk("rst_redirect", redirect, 0);
    rst = 1'b0; #1;
    chk("seq_write", if_id_write, 1);
    chk("seq_plus4", pc_plus4, 32'h0040_0004);
    tick; chk("seq_pc1", pc, 32'h0040_0004);
    tick; chk("seq_pc2", pc, 32'h0040_0008);
    jump_op = 2'b11; jump_target = 32'hFFFF_FFFC; #1;
    chk("wrap_redirect", redirect, 1);
    chk("wrap_flush", if_id_flush, 1);
    chk("wrap_write", if_id_write, 0);
    tick; chk("wrap_pc_top", pc, 32'hFFFF_FFFC);
    jump_op = 2'b00; #1;
    chk("wrap_squash_write", if_id_write, 1);
    chk("wrap_squash_flush", if_id_flush, 0);
    tick; chk("wrap_pc_zero", pc, 32'h0000_0000);
    jump_op = 2'b11; jump_target = 32'h1C; tick;
    jump_op = 2'b00; tick; chk("br_setup_pc", pc, 32'h20);
    jump_op = 2'b01; branch_target = 32'h100; #1;
    chk("br_flush", if_id_flush, 1);
    chk("br_redirect", redirect, 1);
    tick; chk("br_pc", pc, 32'h100);
    jump_op = 2'b11; jump_target = 32'h800; #1;
    chk("br_squash_redirect", redirect, 0);
    chk("br_squash_write", if_id_write, 1);
    tick; chk("br_squash_pc", pc, 32'h104);
    jump_op = 2'b10; reg_ready = 1'b0; reg_target = 32'h203; #1;
    chk("jr_wait_write", if_id_write, 0);
    chk("jr_wait_flush", if_id_flush, 0);
    tick; chk("jr_wait_pc1", pc, 32'h104);
    tick; chk("jr_wait_pc2", pc, 32'h104);
    reg_ready = 1'b1; #1;
    chk("jr_redirect", redirect, 1);
    tick; chk("jr_pc", pc, 32'h200);
    jump_op = 2'b00; tick; chk("jr_after_pc", pc, 32'h204);
    jump_op = 2'b11; jump_target = 32'h800; imem_ready = 1'b0; #1;
    chk("busy_flush1", if_id_flush, 1);
    chk("busy_redirect1", redirect, 0);
    tick; chk("busy_pc1", pc, 32'h204);
    jump_op = 2'b01; branch_target = 32'h300; #1;
    chk("busy_flush2", if_id_flush, 1);
    tick; chk("busy_pc2", pc, 32'h204);
    jump_op = 2'b00; #1;
    chk("busy_flush3", if_id_flush, 1);
    chk("busy_write3", if_id_write, 0);
    tick; chk("busy_pc3", pc, 32'h204);
    imem_ready = 1'b1; #1;
    chk("busy_redirect", redirect, 1);
    tick; chk("busy_pc", pc, 32'h800);
    tick; chk("busy_after_pc", pc, 32'h804);
    stall = 1'b1; jump_op = 2'b11; jump_target = 32'h900; #1;
    chk("stall_flush", if_id_flush, 0);
    chk("stall_write", if_id_write, 0);
    tick; chk("stall_pc1", pc, 32'h804);
    tick; chk("stall_pc2", pc, 32'h804);
    stall = 1'b0; #1;
    chk("stall_redirect", redirect, 1);
    tick; chk("stall_pc", pc, 32'h900);
    jump_op = 2'b00; tick; chk("stall_after_pc", pc, 32'h904);
    jump_op = 2'b11; jump_target = 32'hA00; imem_ready = 1'b0; tick;
    chk("pend_hold_pc", pc, 32'h904);
    rst = 1'b1; #1;
    chk("pend_rst_flush", if_id_flush, 0);
    chk("pend_rst_redirect", redirect, 0);
    tick; chk("pend_rst_pc", pc, RPC);
`ifdef PC_SEQ_PERF_CNT_EN
    chk("cnt_redirect_clr", redirect_cnt, 0);
    chk("cnt_hold_clr", hold_cnt, 0);
`endif
    rst = 1'b0; jump_op = 2'b00; imem_ready = 1'b1; #1;
    chk("post_rst_write", if_id_write, 1);
    chk("post_rst_redirect", redirect, 0);
    tick; chk("post_rst_pc", pc, 32'h0040_0004);
    tick; chk("post_rst_pc2", pc, 32'h0040_0008);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Owns the fetch PC register of the pipelined MIPS core and turns the 2-bit jump decision from the ID-stage jump control into PC updates, IF/ID squashes and fetch holds. It arbitrates between load-use stalls, register-indirect jumps still waiting on their operand, and an instruction memory that may not accept a fetch every cycle. It sits between the jump control / hazard unit and the IF stage (PC register, imem address, IF/ID pipeline register).

## Interface
- PC_W, 32, PC and target width
- RESET_PC, 0, PC value loaded on reset (low 2 bits must be 0)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- jump_op  in  2  00 PC+4, 01 branch taken, 10 jr/jalr, 11 j/jal
- branch_target  in  PC_W  target for 01
- reg_target  in  PC_W  target for 10 (forwarded rs)
- jump_target  in  PC_W  target for 11
- reg_ready  in  1  reg_target valid; 0 = operand still in flight
- stall  in  1  load-use stall from hazard unit
- imem_ready  in  1  imem accepts a fetch this cycle
- pc  out  PC_W  registered fetch address
- pc_plus4  out  PC_W  pc+4, combinational
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID captures a bubble at this edge
- redirect  out  1  one-cycle pulse: PC loaded with a non-sequential target this edge

## Operation
- States: RUN, PEND, SQUASH. Reset state RUN.
- hold_req = stall | (jump_op==10 & !reg_ready). redir_req = (jump_op!=00) & !hold_req.
- target = mux(jump_op: 01 branch_target, 10 reg_target, 11 jump_target); bits [1:0] forced to 00 on every PC load.
- RUN, priority top-down:
  - hold_req: pc held, if_id_write=0, if_id_flush=0, stay RUN.
  - redir_req & imem_ready: pc<=target, if_id_flush=1, if_id_write=0, redirect=1, next SQUASH.
  - redir_req & !imem_ready: pend_pc<=target, if_id_flush=1, if_id_write=0, next PEND.
  - otherwise: imem_ready ? (pc<=pc+4, if_id_write=1) : (pc held, if_id_write=0).
- PEND: jump_op/stall ignored; pc held; if_id_write=0; if_id_flush=1. On imem_ready: pc<=pend_pc, redirect=1, next SQUASH.
- SQUASH (exactly one cycle): jump_op and stall ignored (ID holds bubble); sequential fetch rule as RUN "otherwise"; next RUN unconditionally.
- pc+4 wraps modulo 2^PC_W.

## Timing
- Reset: at the edge with rst=1, pc=RESET_PC, pend_pc=0, state RUN. While rst=1: if_id_write=0, if_id_flush=0, redirect=0.
- if_id_write, if_id_flush, redirect are combinational from state and inputs of the current cycle; pc changes only at edges.
- Redirect latency: jump_op!=00 sampled in cycle N with imem_ready=1 gives pc=target in N+1; first target-path instruction enters IF/ID at end of N+1.
- Taken-redirect penalty: 1 bubble (plus imem wait cycles spent in PEND).
- stall with jump_op!=00 in the same cycle: stall wins; redirect taken in the first cycle stall drops.
- jr/jalr with reg_ready=0: held indefinitely, no flush, until reg_ready=1.
- rst mid-PEND or mid-SQUASH: pending target discarded, RUN next.

## Configuration
- PC_SEQ_PERF_CNT_EN defined: adds outputs redirect_cnt[31:0] (+1 per redirect pulse) and hold_cnt[31:0] (+1 per RUN cycle with hold_req=1). Both cleared by rst, saturate at 0xFFFFFFFF.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset/sequential: RESET_PC=0x00400000, rst 2 cycles, imem_ready=1 -> pc 0x00400000, 0x00400004, 0x00400008; if_id_write=1 after reset; pc=0xFFFFFFFC wraps to 0x00000000.
- Branch: pc=0x20, jump_op=01, branch_target=0x100 -> if_id_flush=1 and redirect=1 same cycle; pc=0x100; next cycle jump_op=11 ignored (SQUASH); then pc=0x104.
- jr wait: jump_op=10, reg_ready=0 for 2 cycles -> pc held, if_id_write=0, flush=0; then reg_ready=1, reg_target=0x203 -> pc=0x200.
- imem busy: jump_op=11, jump_target=0x800, imem_ready=0 for 3 cycles -> PEND, pc held, if_id_flush=1 for 3 cycles; first ready cycle -> pc=0x800, redirect=1.
- Stall priority: stall=1 with jump_op=11 for 2 cycles -> pc held, no flush; stall=0 -> redirect to jump_target next edge.
- Reset in PEND: rst=1 during PEND -> pc=RESET_PC, pend target never loaded; with PC_SEQ_PERF_CNT_EN, counters read 0.
